// File: rtl/idex_hazard_reg_pkg.sv
// Shared pipeline definitions for the ID/EX stage: default widths, ALU op
// encodings, the register-0 constant and the packed ID/EX control bundle.
package idex_hazard_reg_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_W_DEF   = 5;
  localparam int ALUOP_W_DEF = 4;

  // Register $zero: a load targeting it never creates a real dependency
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [ALUOP_W_DEF-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } aluop_e;

  typedef struct packed {
    logic                   RegWriteEn;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   ALUSrc;
    logic [ALUOP_W_DEF-1:0] ALUop;
  } idex_ctrl_t;

  // Saturating increment used by the optional statistics counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/idex_hazard_reg_load_use_detect.sv
// Combinational load-use comparator: flags when the instruction in EX is a
// load whose nonzero destination is read by the instruction in ID. Shared
// with the dual-issue pairing check.
module load_use_detect
  import idex_hazard_reg_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             valid_ex_i,
  input  logic             memread_ex_i,
  input  logic [REG_W-1:0] dest_ex_i,
  input  logic             valid_id_i,
  input  logic [REG_W-1:0] rs_id_i,
  input  logic [REG_W-1:0] rt_id_i,
  output logic             lu_o
);

  // A hazard needs a live load in EX, a live consumer in ID and a real register match
  always_comb begin
    lu_o = valid_ex_i & memread_ex_i & valid_id_i &
           (dest_ex_i != REG_W'(REG_ZERO)) &
           ((dest_ex_i == rs_id_i) | (dest_ex_i == rt_id_i));
  end

endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// global hold. The BUBBLE state is the registered bubble itself
// (valid_IDEX=0 with MemRead_IDEX=0), which keeps load-use from recurring
// on the next cycle. Optional stall/flush statistics counters are enabled by
// defining IDEX_STALL_STATS_EN.
module idex_hazard_reg
  import idex_hazard_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_ID,
  input  logic [REG_W-1:0]   rs_ID,
  input  logic [REG_W-1:0]   rt_ID,
  input  logic [REG_W-1:0]   rd_ID,
  input  logic               RegDst_ID,
  input  logic               RegWriteEn_ID,
  input  logic               MemRead_ID,
  input  logic               MemWrite_ID,
  input  logic               ALUSrc_ID,
  input  logic [ALUOP_W-1:0] ALUop_ID,
  input  logic [DATA_W-1:0]  readData1_ID,
  input  logic [DATA_W-1:0]  readData2_ID,
  input  logic [DATA_W-1:0]  imm_ID,
  input  logic               flush,
  input  logic               hold,
  output logic               valid_IDEX,
  output logic [REG_W-1:0]   rs_IDEX,
  output logic [REG_W-1:0]   rt_IDEX,
  output logic [REG_W-1:0]   writeRegister_IDEX,
  output logic               RegWriteEn_IDEX,
  output logic               MemRead_IDEX,
  output logic               MemWrite_IDEX,
  output logic               ALUSrc_IDEX,
  output logic [ALUOP_W-1:0] ALUop_IDEX,
  output logic [DATA_W-1:0]  readData1_IDEX,
  output logic [DATA_W-1:0]  readData2_IDEX,
  output logic [DATA_W-1:0]  imm_IDEX,
  output logic               stall_ID
`ifdef IDEX_STALL_STATS_EN
  ,
  output logic [31:0]        lu_stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  logic               valid_q;
  logic [REG_W-1:0]   rs_q;
  logic [REG_W-1:0]   rt_q;
  logic [REG_W-1:0]   wr_q;
  logic               rwe_q;
  logic               mr_q;
  logic               mw_q;
  logic               alusrc_q;
  logic [ALUOP_W-1:0] aluop_q;
  logic [DATA_W-1:0]  rd1_q;
  logic [DATA_W-1:0]  rd2_q;
  logic [DATA_W-1:0]  imm_q;
  logic               lu;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .valid_ex_i  (valid_q),
    .memread_ex_i(mr_q),
    .dest_ex_i   (wr_q),
    .valid_id_i  (valid_ID),
    .rs_id_i     (rs_ID),
    .rt_id_i     (rt_ID),
    .lu_o        (lu)
  );

  // Front end freezes on hold, or on a load-use hazard unless a flush kills the consumer
  always_comb begin
    stall_ID = hold | (lu & ~flush);
  end

  // Pipeline register: reset > flush bubble > hold > load-use bubble > load from ID
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      wr_q     <= '0;
      rwe_q    <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      alusrc_q <= 1'b0;
      aluop_q  <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
    end else if (flush || (!hold && lu)) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      wr_q    <= '0;
      rwe_q   <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
    end else if (!hold) begin
      valid_q  <= valid_ID;
      rs_q     <= rs_ID;
      rt_q     <= rt_ID;
      wr_q     <= RegDst_ID ? rd_ID : rt_ID;
      rwe_q    <= RegWriteEn_ID & valid_ID;
      mr_q     <= MemRead_ID & valid_ID;
      mw_q     <= MemWrite_ID & valid_ID;
      alusrc_q <= ALUSrc_ID;
      aluop_q  <= ALUop_ID;
      rd1_q    <= readData1_ID;
      rd2_q    <= readData2_ID;
      imm_q    <= imm_ID;
    end
  end

  assign valid_IDEX         = valid_q;
  assign rs_IDEX            = rs_q;
  assign rt_IDEX            = rt_q;
  assign writeRegister_IDEX = wr_q;
  assign RegWriteEn_IDEX    = rwe_q;
  assign MemRead_IDEX       = mr_q;
  assign MemWrite_IDEX      = mw_q;
  assign ALUSrc_IDEX        = alusrc_q;
  assign ALUop_IDEX         = aluop_q;
  assign readData1_IDEX     = rd1_q;
  assign readData2_IDEX     = rd2_q;
  assign imm_IDEX           = imm_q;

`ifdef IDEX_STALL_STATS_EN
  logic [31:0] lu_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating event counters: real load-use stalls and flush edges
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu && !flush && !hold) lu_cnt_q <= sat_inc32(lu_cnt_q);
      if (flush) flush_cnt_q <= sat_inc32(flush_cnt_q);
    end
  end

  assign lu_stall_cnt = lu_cnt_q;
  assign flush_cnt    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Self-checking bench for idex_hazard_reg: a table of directed vectors run
// back to back, plus hand sequences for reset, hold and reset-during-stall.
// Counter checks are compiled in when IDEX_STALL_STATS_EN is defined.
module tb_idex_hazard_reg;

  logic        clk;
  logic        rst;
  logic        valid_ID;
  logic [4:0]  rs_ID, rt_ID, rd_ID;
  logic        RegDst_ID, RegWriteEn_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID;
  logic [3:0]  ALUop_ID;
  logic [31:0] readData1_ID, readData2_ID, imm_ID;
  logic        flush, hold;
  logic        valid_IDEX;
  logic [4:0]  rs_IDEX, rt_IDEX, writeRegister_IDEX;
  logic        RegWriteEn_IDEX, MemRead_IDEX, MemWrite_IDEX, ALUSrc_IDEX;
  logic [3:0]  ALUop_IDEX;
  logic [31:0] readData1_IDEX, readData2_IDEX, imm_IDEX;
  logic        stall_ID;
`ifdef IDEX_STALL_STATS_EN
  logic [31:0] lu_stall_cnt, flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  idex_hazard_reg dut (
    .clk               (clk),
    .rst               (rst),
    .valid_ID          (valid_ID),
    .rs_ID             (rs_ID),
    .rt_ID             (rt_ID),
    .rd_ID             (rd_ID),
    .RegDst_ID         (RegDst_ID),
    .RegWriteEn_ID     (RegWriteEn_ID),
    .MemRead_ID        (MemRead_ID),
    .MemWrite_ID       (MemWrite_ID),
    .ALUSrc_ID         (ALUSrc_ID),
    .ALUop_ID          (ALUop_ID),
    .readData1_ID      (readData1_ID),
    .readData2_ID      (readData2_ID),
    .imm_ID            (imm_ID),
    .flush             (flush),
    .hold              (hold),
    .valid_IDEX        (valid_IDEX),
    .rs_IDEX           (rs_IDEX),
    .rt_IDEX           (rt_IDEX),
    .writeRegister_IDEX(writeRegister_IDEX),
    .RegWriteEn_IDEX   (RegWriteEn_IDEX),
    .MemRead_IDEX      (MemRead_IDEX),
    .MemWrite_IDEX     (MemWrite_IDEX),
    .ALUSrc_IDEX       (ALUSrc_IDEX),
    .ALUop_IDEX        (ALUop_IDEX),
    .readData1_IDEX    (readData1_IDEX),
    .readData2_IDEX    (readData2_IDEX),
    .imm_IDEX          (imm_IDEX),
    .stall_ID          (stall_ID)
`ifdef IDEX_STALL_STATS_EN
    ,
    .lu_stall_cnt      (lu_stall_cnt),
    .flush_cnt         (flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int vld, rs, rt, rd, regDst, rwe, mr, mw, fl, d1;
    int eStall, eVld, eRs, eRt, eWr, eRwe, eMr, eMw, chkData;
  } vec_t;

  vec_t vecs[11];

  task automatic applyStimulus(input int v, input int rs, input int rt, input int rd,
                               input int regDst, input int rwe, input int mr, input int mw,
                               input int alusrc, input int aluop, input int d1,
                               input int fl, input int ho);
    valid_ID      = v[0];
    rs_ID         = 5'(rs);
    rt_ID         = 5'(rt);
    rd_ID         = 5'(rd);
    RegDst_ID     = regDst[0];
    RegWriteEn_ID = rwe[0];
    MemRead_ID    = mr[0];
    MemWrite_ID   = mw[0];
    ALUSrc_ID     = alusrc[0];
    ALUop_ID      = 4'(aluop);
    readData1_ID  = 32'(d1);
    readData2_ID  = 32'(d1) ^ 32'hFFFF_0000;
    imm_ID        = 32'(d1) + 32'd1;
    flush         = fl[0];
    hold          = ho[0];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRegs(input string tag, input int v, input int rs, input int rt,
                           input int wr, input int rwe, input int mr, input int mw);
    checkOutput({tag, ".valid"}, 32'(valid_IDEX), 32'(v));
    checkOutput({tag, ".rs"}, 32'(rs_IDEX), 32'(rs));
    checkOutput({tag, ".rt"}, 32'(rt_IDEX), 32'(rt));
    checkOutput({tag, ".wr"}, 32'(writeRegister_IDEX), 32'(wr));
    checkOutput({tag, ".rwe"}, 32'(RegWriteEn_IDEX), 32'(rwe));
    checkOutput({tag, ".mr"}, 32'(MemRead_IDEX), 32'(mr));
    checkOutput({tag, ".mw"}, 32'(MemWrite_IDEX), 32'(mw));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           vld rs rt rd dst rwe mr mw fl d1     | stall vld rs rt wr rwe mr mw chk
    vecs[0]  = '{1, 3, 4, 5, 1, 1, 0, 0, 0, 'h11,   0, 1, 3, 4, 5, 1, 0, 0, 1};
    vecs[1]  = '{1, 2, 8, 9, 0, 1, 1, 0, 0, 'h22,   0, 1, 2, 8, 8, 1, 1, 0, 1};
    vecs[2]  = '{1, 8, 1, 10, 1, 1, 0, 0, 0, 'h33,  1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 8, 1, 10, 1, 1, 0, 0, 0, 'h33,  0, 1, 8, 1, 10, 1, 0, 0, 1};
    vecs[4]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 'h44,   0, 1, 1, 0, 0, 1, 1, 0, 1};
    vecs[5]  = '{1, 0, 0, 7, 1, 1, 0, 1, 0, 'h55,   0, 1, 0, 0, 7, 1, 0, 1, 1};
    vecs[6]  = '{1, 3, 12, 0, 0, 1, 1, 0, 0, 'h66,  0, 1, 3, 12, 12, 1, 1, 0, 1};
    vecs[7]  = '{1, 5, 12, 13, 1, 1, 0, 0, 1, 'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 12, 12, 4, 1, 1, 1, 1, 0, 'h78, 0, 0, 12, 12, 4, 0, 0, 0, 1};
    vecs[9]  = '{1, 1, 6, 0, 0, 1, 1, 0, 0, 'h88,   0, 1, 1, 6, 6, 1, 1, 0, 1};
    vecs[10] = '{0, 6, 2, 3, 1, 1, 0, 0, 0, 'h99,   0, 0, 6, 2, 3, 0, 0, 0, 1};

    // Reset with a busy-looking ID slot
    rst = 1'b1;
    applyStimulus(1, 8, 8, 8, 1, 1, 1, 1, 1, 5, 'h1234, 0, 0);
    tick;
    tick;
    checkRegs("reset", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset.stall", 32'(stall_ID), 32'd0);
    checkOutput("reset.rd1", readData1_IDEX, 32'd0);
    checkOutput("reset.imm", imm_IDEX, 32'd0);
    checkOutput("reset.aluop", 32'(ALUop_IDEX), 32'd0);
`ifdef IDEX_STALL_STATS_EN
    checkOutput("reset.lucnt", lu_stall_cnt, 32'd0);
    checkOutput("reset.flcnt", flush_cnt, 32'd0);
`endif
    rst = 1'b0;

    // Table-driven stream: each vector's stall depends on the previous one's result
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].vld, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].regDst,
                    vecs[i].rwe, vecs[i].mr, vecs[i].mw, i % 2, i, vecs[i].d1,
                    vecs[i].fl, 0);
      #1;
      checkOutput($sformatf("v%0d.stall", i), 32'(stall_ID), 32'(vecs[i].eStall));
      tick;
      checkRegs($sformatf("v%0d", i), vecs[i].eVld, vecs[i].eRs, vecs[i].eRt,
                vecs[i].eWr, vecs[i].eRwe, vecs[i].eMr, vecs[i].eMw);
      if (vecs[i].chkData != 0) begin
        checkOutput($sformatf("v%0d.rd1", i), readData1_IDEX, 32'(vecs[i].d1));
        checkOutput($sformatf("v%0d.rd2", i), readData2_IDEX, 32'(vecs[i].d1) ^ 32'hFFFF_0000);
        checkOutput($sformatf("v%0d.imm", i), imm_IDEX, 32'(vecs[i].d1) + 32'd1);
        checkOutput($sformatf("v%0d.aluop", i), 32'(ALUop_IDEX), 32'(i));
        if (vecs[i].eVld != 0)
          checkOutput($sformatf("v%0d.alusrc", i), 32'(ALUSrc_IDEX), 32'(i % 2));
      end
    end
`ifdef IDEX_STALL_STATS_EN
    checkOutput("tbl.lucnt", lu_stall_cnt, 32'd1);
    checkOutput("tbl.flcnt", flush_cnt, 32'd1);
`endif

    // Hold for 3 cycles with a valid instruction in EX
    applyStimulus(1, 3, 4, 5, 1, 1, 0, 0, 1, 2, 'hAA, 0, 0);
    tick;
    checkRegs("hpre", 1, 3, 4, 5, 1, 0, 0);
    applyStimulus(1, 9, 9, 9, 0, 1, 1, 1, 0, 7, 'hEE, 0, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("hold%0d.stall", c), 32'(stall_ID), 32'd1);
      tick;
      checkRegs($sformatf("hold%0d", c), 1, 3, 4, 5, 1, 0, 0);
      checkOutput($sformatf("hold%0d.rd1", c), readData1_IDEX, 32'hAA);
      checkOutput($sformatf("hold%0d.aluop", c), 32'(ALUop_IDEX), 32'd2);
`ifdef IDEX_STALL_STATS_EN
      checkOutput($sformatf("hold%0d.lucnt", c), lu_stall_cnt, 32'd1);
      checkOutput($sformatf("hold%0d.flcnt", c), flush_cnt, 32'd1);
`endif
    end

    // Hold while a load-use hazard is pending, then release
    applyStimulus(1, 1, 8, 0, 0, 1, 1, 0, 0, 0, 'h10, 0, 0);
    #1;
    checkOutput("hlu.pre.stall", 32'(stall_ID), 32'd0);
    tick;
    checkRegs("hlu.lw", 1, 1, 8, 8, 1, 1, 0);
    applyStimulus(1, 8, 2, 11, 1, 1, 0, 0, 0, 3, 'h20, 0, 1);
    #1;
    checkOutput("hlu.held.stall", 32'(stall_ID), 32'd1);
    tick;
    checkRegs("hlu.held", 1, 1, 8, 8, 1, 1, 0);
    hold = 1'b0;
    #1;
    checkOutput("hlu.rel.stall", 32'(stall_ID), 32'd1);
    tick;
    checkRegs("hlu.bubble", 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("hlu.after.stall", 32'(stall_ID), 32'd0);
    tick;
    checkRegs("hlu.dep", 1, 8, 2, 11, 1, 0, 0);
    checkOutput("hlu.dep.rd1", readData1_IDEX, 32'h20);
`ifdef IDEX_STALL_STATS_EN
    checkOutput("hlu.lucnt", lu_stall_cnt, 32'd2);
`endif

    // Reset asserted while a load-use stall is active
    applyStimulus(1, 1, 8, 0, 0, 1, 1, 0, 0, 0, 'h30, 0, 0);
    tick;
    applyStimulus(1, 8, 3, 12, 1, 1, 0, 0, 0, 1, 'h40, 0, 0);
    #1;
    checkOutput("rstst.stall", 32'(stall_ID), 32'd1);
    rst = 1'b1;
    tick;
    checkRegs("rstst", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rstst.rd1", readData1_IDEX, 32'd0);
`ifdef IDEX_STALL_STATS_EN
    checkOutput("rstst.lucnt", lu_stall_cnt, 32'd0);
    checkOutput("rstst.flcnt", flush_cnt, 32'd0);
`endif
    rst = 1'b0;
    #1;
    checkOutput("rstst.after.stall", 32'(stall_ID), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
